// File: rtl/logicnet_lut_pkg.sv
// Shared types and sizing helpers for the runtime-programmable LUT neuron.
package logicnet_lut_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } lut_state_t;

  // Number of CFG_W-bit beats needed to fill a 2^in_bits x out_bits table.
  function automatic int unsigned beats(input int unsigned in_bits,
                                        input int unsigned out_bits,
                                        input int unsigned cfg_w);
    return ((32'd1 << in_bits) * out_bits) / cfg_w;
  endfunction

  // The flat table must split into a whole number of config beats.
  function automatic bit beats_ok(input int unsigned in_bits,
                                  input int unsigned out_bits,
                                  input int unsigned cfg_w);
    return (cfg_w != 0) && ((((32'd1 << in_bits) * out_bits) % cfg_w) == 0);
  endfunction

  // Beat counter width: $clog2(n) bits, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logicnet_lut_loader_ram.sv
// DEPTH x OUT_BITS distributed table: CFG_W-wide beat write port, registered entry read port.
module lut_table_ram
  import logicnet_lut_pkg::*;
#(
  parameter int unsigned IN_BITS  = 6,
  parameter int unsigned OUT_BITS = 1,
  parameter int unsigned CFG_W    = 8,
  parameter int unsigned BEATS    = 8,
  parameter int unsigned CW       = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [CW-1:0]       waddr,
  input  logic [CFG_W-1:0]    wdata,
  input  logic                re,
  input  logic [IN_BITS-1:0]  raddr,
  output logic                rvalid,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << IN_BITS;
  localparam int unsigned FLAT  = DEPTH * OUT_BITS;

  // Flat bit b holds entry b/OUT_BITS, bit b%OUT_BITS; beat k covers [k*CFG_W +: CFG_W].
  logic [FLAT-1:0] mem;

  // Beat write port; cleared on reset so an unprogrammed table reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (waddr == CW'(k)) mem[k*CFG_W +: CFG_W] <= wdata;
      end
    end
  end

  // Registered read; sees the pre-write contents when a write lands in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= re;
      if (re) begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
          if (raddr == IN_BITS'(e)) rdata <= mem[e*OUT_BITS +: OUT_BITS];
        end
      end
    end
  end

endmodule

// File: rtl/logicnet_lut_loader.sv
// LogicNets LUT neuron loader: streams a truth table in, then serves 1-cycle lookups.
module logicnet_lut_loader
  import logicnet_lut_pkg::*;
#(
  parameter int unsigned IN_BITS  = 6,
  parameter int unsigned OUT_BITS = 1,
  parameter int unsigned CFG_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                cfg_last,
  output logic                cfg_err,
  output logic                loaded,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int unsigned BEATS = beats(IN_BITS, OUT_BITS, CFG_W);
  localparam int unsigned CW    = cnt_width(BEATS);

  if (!beats_ok(IN_BITS, OUT_BITS, CFG_W)) begin : g_cfg_check
    $error("logicnet_lut_loader: table size is not a multiple of CFG_W");
  end

  lut_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_nxt;
  logic          accept;
  logic [CW-1:0] beat_idx;
  logic          final_beat;
  logic          wr_en;
  logic          rd_en;

  // Every state takes beats; readiness only drops while reset is held.
  assign cfg_ready = rst_n;
  assign accept    = cfg_valid & cfg_ready;
  assign loaded    = (state == READY);
  assign in_ready  = loaded;
  assign rd_en     = in_valid & in_ready;

  // State, beat counter and sticky error register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cfg_err <= err_nxt;
    end
  end

  // Framing: a beat from EMPTY/READY is always beat 0; cfg_last must coincide with the final beat.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    err_nxt    = cfg_err;
    wr_en      = 1'b0;
    beat_idx   = (state == LOAD) ? cnt : '0;
    final_beat = (beat_idx == CW'(BEATS - 1));
    if (accept) begin
      wr_en = 1'b1;
      if (final_beat && cfg_last) begin
        state_nxt = READY;
        cnt_nxt   = '0;
      end else if (final_beat || cfg_last) begin
        state_nxt = EMPTY;
        cnt_nxt   = '0;
        err_nxt   = 1'b1;
      end else begin
        state_nxt = LOAD;
        cnt_nxt   = beat_idx + CW'(1);
      end
    end
  end

  lut_table_ram #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .CFG_W    (CFG_W),
    .BEATS    (BEATS),
    .CW       (CW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wr_en),
    .waddr  (beat_idx),
    .wdata  (cfg_data),
    .re     (rd_en),
    .raddr  (in_data),
    .rvalid (out_valid),
    .rdata  (out_data)
  );

endmodule

// File: tb/tb_logicnet_lut_loader.sv
// Self-checking bench for logicnet_lut_loader: fixed vectors, directed corners, random vs model.
module tb_logicnet_lut_loader;

  localparam int unsigned NB = 8;   // beats per table at default parameters

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_data = '0;
  logic       cfg_last = 1'b0;
  logic       cfg_err;
  logic       loaded;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_data = '0;
  logic       out_valid;
  logic [0:0] out_data;

  int total = 0;
  int bad   = 0;

  // Reference model: the table as a flat bit vector plus frame progress.
  logic [63:0] m_tab;
  int          m_n;
  bit          m_ld, m_err, m_ov;
  logic        m_od;

  always #5 clk = ~clk;

  logicnet_lut_loader #(
    .IN_BITS  (6),
    .OUT_BITS (1),
    .CFG_W    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .cfg_err   (cfg_err),
    .loaded    (loaded),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, sample #1 after the edge and compare.
  task automatic cyc(input bit rn, input bit cv, input logic [7:0] cd, input bit cl,
                     input bit iv, input logic [5:0] ia);
    int k;
    rst_n = rn; cfg_valid = cv; cfg_data = cd; cfg_last = cl;
    in_valid = iv; in_data = ia;
    if (!rn) begin
      m_tab = '0; m_n = 0; m_ld = 0; m_err = 0; m_ov = 0; m_od = 1'b0;
    end else begin
      m_ov = iv && m_ld;
      if (m_ov) m_od = m_tab[ia];
      if (cv) begin
        k = m_n;
        m_tab[k*8 +: 8] = cd;
        if (cl && k == NB - 1) begin
          m_ld = 1; m_n = 0;
        end else if (cl || k == NB - 1) begin
          m_err = 1; m_ld = 0; m_n = 0;
        end else begin
          m_ld = 0; m_n = k + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data",  32'(out_data),  32'(m_od));
    chk("loaded",    32'(loaded),    32'(m_ld));
    chk("cfg_err",   32'(cfg_err),   32'(m_err));
    chk("in_ready",  32'(in_ready),  32'(m_ld));
    chk("cfg_ready", 32'(cfg_ready), 32'(rn));
  endtask

  task automatic load_table(input logic [7:0] b);
    for (int i = 0; i < int'(NB); i++) cyc(1, 1, b, i == int'(NB) - 1, 0, '0);
  endtask

  typedef struct {
    bit         cv;
    logic [7:0] cd;
    bit         cl;
    bit         iv;
    logic [5:0] ia;
    bit         e_ov;
    logic       e_od;
    bit         e_ld;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] pat;
    bit cv, cl, iv, rn;

    // Test 1 and 2 as fixed vectors with literal expectations.
    vecs.push_back('{0, 8'h00, 0, 1, 6'd5, 0, 1'b0, 0});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1, 8'hA5, (i == 7), 0, 6'd0, 0, 1'b0, (i == 7)});
    vecs.push_back('{0, 8'h00, 0, 1, 6'd0, 1, 1'b1, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 6'd0, 0, 1'b1, 1});
    vecs.push_back('{0, 8'h00, 0, 1, 6'd1, 1, 1'b0, 1});
    vecs.push_back('{0, 8'h00, 0, 1, 6'd2, 1, 1'b1, 1});
    vecs.push_back('{0, 8'h00, 0, 1, 6'd5, 1, 1'b1, 1});
    vecs.push_back('{0, 8'h00, 0, 1, 6'd6, 1, 1'b0, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 6'd0, 0, 1'b0, 1});

    cyc(0, 0, '0, 0, 0, '0);
    cyc(0, 0, '0, 0, 0, '0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);

    foreach (vecs[i]) begin
      cyc(1, vecs[i].cv, vecs[i].cd, vecs[i].cl, vecs[i].iv, vecs[i].ia);
      chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_ld", i), 32'(loaded), 32'(vecs[i].e_ld));
      if (vecs[i].e_ov) chk($sformatf("vec%0d_od", i), 32'(out_data), 32'(vecs[i].e_od));
    end

    // Test 3: back-to-back sweep of every address.
    pat = 8'hA5;
    for (int a = 0; a < 64; a++) begin
      cyc(1, 0, '0, 0, 1, 6'(a));
      chk("sweep_ov", 32'(out_valid), 32'd1);
      chk("sweep_od", 32'(out_data), 32'(pat[a % 8]));
    end
    cyc(1, 0, '0, 0, 0, '0);
    chk("sweep_end_ov", 32'(out_valid), 32'd0);

    // Test 4: early cfg_last is a framing error; a clean reload still succeeds.
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'h3C, i == 3, 0, '0);
    chk("early_last_err", 32'(cfg_err), 32'd1);
    chk("early_last_ld", 32'(loaded), 32'd0);
    cyc(1, 0, '0, 0, 1, 6'd3);
    chk("no_lookup_unloaded", 32'(out_valid), 32'd0);
    load_table(8'hFF);
    chk("ff_loaded", 32'(loaded), 32'd1);
    for (int a = 0; a < 64; a += 7) begin
      cyc(1, 0, '0, 0, 1, 6'(a));
      chk("ff_od", 32'(out_data), 32'd1);
    end
    chk("err_sticky", 32'(cfg_err), 32'd1);

    // Missing cfg_last on the final beat is also an error.
    for (int i = 0; i < 8; i++) cyc(1, 1, 8'h11, 0, 0, '0);
    chk("no_last_ld", 32'(loaded), 32'd0);

    // Test 5: reload beat and lookup in the same cycle read the old table.
    load_table(8'hA5);
    cyc(1, 1, 8'h00, 0, 1, 6'd0);
    chk("rbw_od", 32'(out_data), 32'd1);
    chk("rbw_ov", 32'(out_valid), 32'd1);
    chk("rbw_ld_drop", 32'(loaded), 32'd0);
    for (int i = 1; i < 8; i++) cyc(1, 1, 8'h00, i == 7, 0, '0);
    cyc(1, 0, '0, 0, 1, 6'd0);
    chk("reload_od", 32'(out_data), 32'd0);

    // Test 6: reset mid-load clears status; the next full load works from beat 0.
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'h5A, 0, 0, '0);
    cyc(0, 0, '0, 0, 0, '0);
    chk("midrst_ld", 32'(loaded), 32'd0);
    chk("midrst_err", 32'(cfg_err), 32'd0);
    load_table(8'h96);
    chk("post_rst_ld", 32'(loaded), 32'd1);
    cyc(1, 0, '0, 0, 1, 6'd9);
    chk("post_rst_od", 32'(out_data), 32'd1);

    // Random traffic against the model, mostly well-framed loads.
    for (int n = 0; n < 2000; n++) begin
      rn = ($urandom_range(0, 499) != 0);
      cv = ($urandom_range(0, 3) == 0);
      if (m_n == int'(NB) - 1) cl = ($urandom_range(0, 15) != 0);
      else                     cl = ($urandom_range(0, 31) == 0);
      iv = ($urandom_range(0, 1) == 1);
      cyc(rn, cv, 8'($urandom), cl, iv, 6'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
